auto_opponent: RTL and testbench

Computer-side move generator for the tic-tac-toe game. On a start pulse it snapshots the nine board cells and scans them over several cycles to choose a move. The move priority is: win, then block, then preference order. It drives the game's computer-move interface (`comp_pos` plus a one-cycle `pc` strobe), taking the place of the external pushbutton and switches.

---
 rtl/tictac_pkg.sv | 44 ++++
 rtl/line_eval.sv | 31 +++
 rtl/auto_opponent.sv | 143 ++++++++++++++
 tb/tb_auto_opponent.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/tictac_pkg.sv
// Shared tic-tac-toe definitions: cell encoding, win-line table,
// computer preference order and the move-generator state enum.
package tictac_pkg;

  localparam int unsigned CELL_W    = 2;
  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned NUM_LINES = 8;
  localparam int unsigned IDX_W     = 4;

  typedef logic [CELL_W-1:0] cell_t;
  typedef logic [IDX_W-1:0]  cidx_t;

  localparam cell_t EMPTY   = 2'b00;
  localparam cell_t PLAYER  = 2'b01;
  localparam cell_t COMP    = 2'b10;
  localparam cell_t INVALID = 2'b11;

  // Eight winning lines, three cell indices each; element [0] is the first line.
  localparam logic [0:NUM_LINES-1][0:2][IDX_W-1:0] LINE_TBL = {
    4'd0, 4'd1, 4'd2,
    4'd3, 4'd4, 4'd5,
    4'd6, 4'd7, 4'd8,
    4'd0, 4'd3, 4'd6,
    4'd1, 4'd4, 4'd7,
    4'd2, 4'd5, 4'd8,
    4'd0, 4'd4, 4'd8,
    4'd2, 4'd4, 4'd6
  };

  // Centre, then corners, then edges.
  localparam logic [0:NUM_CELLS-1][IDX_W-1:0] PREF_TBL = {
    4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN_WIN,
    S_SCAN_BLK,
    S_SCAN_PREF,
    S_ISSUE,
    S_NOMOVE
  } state_t;

endpackage

// File: rtl/line_eval.sv
// Evaluates one board line: hit when exactly two cells carry mark_i and
// the third is empty; empty_idx_o names that empty cell.
//   cell_{a,b,c}_i : cell contents     idx_{a,b,c}_i : their board indices
//   mark_i         : mark being tested  hit_o / empty_idx_o : result
module line_eval
  import tictac_pkg::*;
(
  input  cell_t       cell_a_i,
  input  cell_t       cell_b_i,
  input  cell_t       cell_c_i,
  input  cidx_t       idx_a_i,
  input  cidx_t       idx_b_i,
  input  cidx_t       idx_c_i,
  input  cell_t       mark_i,
  output logic        hit_o,
  output cidx_t       empty_idx_o
);

  logic [1:0] n_mark;
  logic [1:0] n_empty;

  always_comb begin
    n_mark  = 2'(cell_a_i == mark_i) + 2'(cell_b_i == mark_i) + 2'(cell_c_i == mark_i);
    n_empty = 2'(cell_a_i == EMPTY) + 2'(cell_b_i == EMPTY) + 2'(cell_c_i == EMPTY);
    hit_o   = (n_mark == 2'd2) && (n_empty == 2'd1);
    if (cell_a_i == EMPTY)      empty_idx_o = idx_a_i;
    else if (cell_b_i == EMPTY) empty_idx_o = idx_b_i;
    else                        empty_idx_o = idx_c_i;
  end

endmodule

// File: rtl/auto_opponent.sv
// Computer move generator: snapshots the board on start, scans for a win,
// then a block, then the first empty cell in preference order, and issues
// the move as a one-cycle pc strobe (or a no_move pulse on a full board).
//   clk, reset       : clock, async active-high reset
//   start            : move request, honoured only in IDLE
//   pos1..pos9       : board cells (pos1 = index 0)
//   pc / comp_pos    : move strobe and chosen cell index
//   busy / no_move   : scan in progress / board full pulse
module auto_opponent
  import tictac_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  output logic       pc,
  output logic [3:0] comp_pos,
  output logic       busy,
  output logic       no_move
);

  state_t                       state_q, state_d;
  cidx_t                        idx_q, idx_d;
  cidx_t                        comp_pos_q, comp_pos_d;
  cell_t [NUM_CELLS-1:0]        snap_q, snap_d;
  logic                         pc_q, pc_d;
  logic                         busy_q, busy_d;
  logic                         no_move_q, no_move_d;

  logic [0:2][IDX_W-1:0]        line;
  cell_t                        mark;
  cidx_t                        pref_cell;
  logic                         hit;
  cidx_t                        empty_idx;

  // Current line / preference entry addressed by the shared index counter.
  always_comb begin
    line      = LINE_TBL[idx_q[2:0]];
    mark      = (state_q == S_SCAN_BLK) ? PLAYER : COMP;
    pref_cell = PREF_TBL[idx_q];
  end

  line_eval u_line_eval (
    .cell_a_i    (snap_q[line[0]]),
    .cell_b_i    (snap_q[line[1]]),
    .cell_c_i    (snap_q[line[2]]),
    .idx_a_i     (line[0]),
    .idx_b_i     (line[1]),
    .idx_c_i     (line[2]),
    .mark_i      (mark),
    .hit_o       (hit),
    .empty_idx_o (empty_idx)
  );

  // State register and outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      comp_pos_q <= '0;
      snap_q     <= '0;
      pc_q       <= 1'b0;
      busy_q     <= 1'b0;
      no_move_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      comp_pos_q <= comp_pos_d;
      snap_q     <= snap_d;
      pc_q       <= pc_d;
      busy_q     <= busy_d;
      no_move_q  <= no_move_d;
    end
  end

  // Next-state logic; outputs are derived from the next state so they
  // line up with the registered state.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    comp_pos_d = comp_pos_q;
    snap_d     = snap_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d  = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
          idx_d   = '0;
          state_d = S_SCAN_WIN;
        end
      end
      S_SCAN_WIN, S_SCAN_BLK: begin
        if (hit) begin
          comp_pos_d = empty_idx;
          idx_d      = '0;
          state_d    = S_ISSUE;
        end else if (idx_q == IDX_W'(NUM_LINES - 1)) begin
          idx_d   = '0;
          state_d = (state_q == S_SCAN_WIN) ? S_SCAN_BLK : S_SCAN_PREF;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_SCAN_PREF: begin
        if (snap_q[pref_cell] == EMPTY) begin
          comp_pos_d = pref_cell;
          idx_d      = '0;
          state_d    = S_ISSUE;
        end else if (idx_q == IDX_W'(NUM_CELLS - 1)) begin
          idx_d   = '0;
          state_d = S_NOMOVE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_ISSUE, S_NOMOVE: begin
        state_d = S_IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    pc_d      = (state_d == S_ISSUE);
    no_move_d = (state_d == S_NOMOVE);
    busy_d    = (state_d != S_IDLE);
  end

  assign pc       = pc_q;
  assign comp_pos = comp_pos_q;
  assign busy     = busy_q;
  assign no_move  = no_move_q;

endmodule

// File: tb/tb_auto_opponent.sv
// Directed bench for auto_opponent: a vector table of boards with the
// expected move, event edge (counted from the start-sampling edge) and
// comp_pos, plus hand sequences for reset abort and snapshot behaviour.
module tb_auto_opponent;

  localparam logic [1:0] E = 2'b00;
  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] C = 2'b10;
  localparam logic [1:0] X = 2'b11;
  localparam int unsigned WIN_CYC = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic       pc;
  logic [3:0] comp_pos;
  logic       busy;
  logic       no_move;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [8:0][1:0] board;   // element k = cell k
    logic            exp_nm;
    int              exp_edge;
    logic [3:0]      exp_pos;
  } vec_t;

  vec_t vecs [10];

  auto_opponent dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pos1     (pos1),
    .pos2     (pos2),
    .pos3     (pos3),
    .pos4     (pos4),
    .pos5     (pos5),
    .pos6     (pos6),
    .pos7     (pos7),
    .pos8     (pos8),
    .pos9     (pos9),
    .pc       (pc),
    .comp_pos (comp_pos),
    .busy     (busy),
    .no_move  (no_move)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_board(input logic [8:0][1:0] b);
    {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1} = b;
  endtask

  // Pulse start so that it is sampled at edge E0, then watch WIN_CYC edges.
  task automatic run_vec(input string tag, input logic [8:0][1:0] b,
                         input logic exp_nm, input int exp_edge,
                         input logic [3:0] exp_pos);
    int pc_cnt = 0, nm_cnt = 0, ev_edge = -1, busy_fall = -1;
    int pos_at_ev = -1;
    @(negedge clk);
    set_board(b);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, " busy after start"}, int'(busy), 1);
    for (int e = 1; e <= WIN_CYC; e++) begin
      @(posedge clk);
      #1;
      if (pc)      begin pc_cnt++; ev_edge = e; pos_at_ev = int'(comp_pos); end
      if (no_move) begin nm_cnt++; ev_edge = e; pos_at_ev = int'(comp_pos); end
      if (!busy && busy_fall < 0) busy_fall = e;
    end
    check({tag, " pc pulses"}, pc_cnt, exp_nm ? 0 : 1);
    check({tag, " no_move pulses"}, nm_cnt, exp_nm ? 1 : 0);
    check({tag, " event edge"}, ev_edge, exp_edge);
    check({tag, " comp_pos at event"}, pos_at_ev, int'(exp_pos));
    check({tag, " busy fall edge"}, busy_fall, exp_edge + 1);
    check({tag, " comp_pos held"}, int'(comp_pos), int'(exp_pos));
  endtask

  initial begin
    // board literals list cell 8 first, cell 0 last
    vecs[0] = '{board: {E,E,E,E,E,E,E,E,E}, exp_nm: 1'b0, exp_edge: 17, exp_pos: 4'd4};
    vecs[1] = '{board: {E,E,E,E,P,P,E,C,C}, exp_nm: 1'b0, exp_edge: 1,  exp_pos: 4'd2};
    vecs[2] = '{board: {E,E,E,E,P,E,C,E,P}, exp_nm: 1'b0, exp_edge: 15, exp_pos: 4'd8};
    vecs[3] = '{board: {P,C,P,C,C,P,P,C,P}, exp_nm: 1'b1, exp_edge: 25, exp_pos: 4'd8};
    vecs[4] = '{board: {E,E,E,E,C,E,C,E,E}, exp_nm: 1'b0, exp_edge: 8,  exp_pos: 4'd6};
    vecs[5] = '{board: {E,E,P,E,E,E,P,E,E}, exp_nm: 1'b0, exp_edge: 16, exp_pos: 4'd4};
    vecs[6] = '{board: {E,E,E,E,X,E,E,X,X}, exp_nm: 1'b0, exp_edge: 19, exp_pos: 4'd2};
    vecs[7] = '{board: {X,E,X,X,X,X,X,X,X}, exp_nm: 1'b0, exp_edge: 25, exp_pos: 4'd7};
    vecs[8] = '{board: {E,E,E,C,E,C,E,P,P}, exp_nm: 1'b0, exp_edge: 2,  exp_pos: 4'd4};
    vecs[9] = '{board: {E,E,E,E,E,E,E,X,C}, exp_nm: 1'b0, exp_edge: 17, exp_pos: 4'd4};

    reset = 1'b1;
    start = 1'b0;
    set_board('0);
    repeat (2) @(posedge clk);
    #1;
    check("reset pc", int'(pc), 0);
    check("reset comp_pos", int'(comp_pos), 0);
    check("reset busy", int'(busy), 0);
    check("reset no_move", int'(no_move), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].board, vecs[i].exp_nm,
              vecs[i].exp_edge, vecs[i].exp_pos);

    // Reset three cycles into a scan aborts it without any strobe.
    begin
      int pc_cnt = 0, nm_cnt = 0;
      @(negedge clk);
      set_board('0);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort busy", int'(busy), 0);
      check("abort pc", int'(pc), 0);
      check("abort comp_pos", int'(comp_pos), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int e = 0; e < WIN_CYC; e++) begin
        @(posedge clk);
        #1;
        if (pc) pc_cnt++;
        if (no_move) nm_cnt++;
      end
      check("abort pc pulses", pc_cnt, 0);
      check("abort no_move pulses", nm_cnt, 0);
      check("abort busy idle", int'(busy), 0);
      run_vec("after abort", {E,E,E,E,E,E,E,E,E}, 1'b0, 17, 4'd4);
    end

    // Board change and start pulses while busy, and start during the pc cycle,
    // must not disturb the snapshotted result or trigger a second request.
    begin
      int pc_cnt = 0, pc_edge = -1, pos_at_pc = -1, busy_after = 0;
      @(negedge clk);
      set_board({E,E,E,E,P,E,E,E,P});
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int e = 1; e <= WIN_CYC + 8; e++) begin
        @(posedge clk);
        #1;
        start = 1'b0;
        if (e == 4) begin
          pos9  = C;
          start = 1'b1;
        end
        if (pc) begin
          pc_cnt++;
          pc_edge   = e;
          pos_at_pc = int'(comp_pos);
          start     = 1'b1;
        end
        if (e > 17 && busy) busy_after++;
      end
      start = 1'b0;
      check("snap pc pulses", pc_cnt, 1);
      check("snap pc edge", pc_edge, 15);
      check("snap comp_pos", pos_at_pc, 8);
      check("snap busy after issue", busy_after, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
